// File: rtl/tt_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tt_time_set_ctrl
// Front-end conditioner for the binary clock's time-setting inputs. The raw
// set-mode switch, direction switch and hour/minute/seconds buttons are
// synchronised and debounced. They are then turned into single-cycle
// increment/decrement pulses, with hold-to-auto-repeat, for tt_bin_clock.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   time_set_i      raw set-mode switch (1 = set, 0 = run)
//   id_switch_i     raw direction switch (1 = increment, 0 = decrement)
//   hour_btn_i      raw hour button, active-high
//   minute_btn_i    raw minute button, active-high
//   seconds_btn_i   raw seconds button, active-high
//   set_mode_o      debounced set-mode level
//   hour_inc_o / hour_dec_o        single-cycle hour step pulses
//   minute_inc_o / minute_dec_o    single-cycle minute step pulses
//   seconds_inc_o / seconds_dec_o  single-cycle seconds step pulses
// ---------------------------------------------------------------------------
module tt_time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic time_set_i,
    input  logic id_switch_i,
    input  logic hour_btn_i,
    input  logic minute_btn_i,
    input  logic seconds_btn_i,
    output logic set_mode_o,
    output logic hour_inc_o,
    output logic hour_dec_o,
    output logic minute_inc_o,
    output logic minute_dec_o,
    output logic seconds_inc_o,
    output logic seconds_dec_o
);

    localparam int NUM_IN = 5;
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD  = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Bit order: 0 set-mode, 1 direction, 2 hour, 3 minute, 4 seconds.
    logic [NUM_IN-1:0] raw_s;
    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;
    logic [NUM_IN-1:0] deb_s;
    logic [2:0]        btn_s;
    logic              any_btn_s;
    logic [1:0]        first_owner_s;
    logic              owner_held_s;

    state_t            state_q;
    logic [1:0]        owner_q;
    logic              dir_q;
    logic [CNT_W-1:0]  rep_cnt_q;
    logic [5:0]        pulse_q;

    // Pulse vector layout: {sec_dec, sec_inc, min_dec, min_inc, hour_dec, hour_inc}.
    function automatic logic [5:0] pulse_sel(input logic [1:0] owner, input logic dir);
        logic [5:0] v;
        case (owner)
            2'd0:    v = dir ? 6'b000001 : 6'b000010;
            2'd1:    v = dir ? 6'b000100 : 6'b001000;
            2'd2:    v = dir ? 6'b010000 : 6'b100000;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    assign raw_s = {seconds_btn_i, minute_btn_i, hour_btn_i, id_switch_i, time_set_i};

    // Two-flop synchroniser for all asynchronous raw inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= {NUM_IN{1'b0}};
            sync2_q <= {NUM_IN{1'b0}};
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
        logic             deb_bit_q;
        logic [CNT_W-1:0] cnt_q;

        // Debounce: count consecutive cycles of disagreement, flip on the last one.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                deb_bit_q <= 1'b0;
                cnt_q     <= {CNT_W{1'b0}};
            end else if (sync2_q[gi] != deb_bit_q) begin
                if (cnt_q == DB_LAST) begin
                    deb_bit_q <= sync2_q[gi];
                    cnt_q     <= {CNT_W{1'b0}};
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= {CNT_W{1'b0}};
            end
        end

        assign deb_s[gi] = deb_bit_q;
    end

    assign btn_s     = deb_s[4:2];
    assign any_btn_s = |btn_s;

    // Priority pick of the new owner: hour over minute over seconds.
    always_comb begin
        first_owner_s = 2'd0;
        if (btn_s[0]) begin
            first_owner_s = 2'd0;
        end else if (btn_s[1]) begin
            first_owner_s = 2'd1;
        end else begin
            first_owner_s = 2'd2;
        end
    end

    // Is the button that owns the FSM still pressed?
    always_comb begin
        owner_held_s = 1'b0;
        case (owner_q)
            2'd0:    owner_held_s = btn_s[0];
            2'd1:    owner_held_s = btn_s[1];
            2'd2:    owner_held_s = btn_s[2];
            default: owner_held_s = 1'b0;
        endcase
    end

    // Press/hold/auto-repeat FSM with registered pulse outputs.
    // A button seen while set mode is off parks the FSM in RELEASE, so a
    // button already held when set mode rises needs a release and re-press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'd0;
            dir_q     <= 1'b0;
            rep_cnt_q <= {CNT_W{1'b0}};
            pulse_q   <= 6'b000000;
        end else begin
            pulse_q <= 6'b000000;
            case (state_q)
                ST_IDLE: begin
                    if (deb_s[0] && any_btn_s) begin
                        owner_q   <= first_owner_s;
                        dir_q     <= deb_s[1];
                        pulse_q   <= pulse_sel(first_owner_s, deb_s[1]);
                        rep_cnt_q <= DELAY_LOAD;
                        state_q   <= ST_HOLD;
                    end else if (any_btn_s) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!deb_s[0] || !owner_held_s) begin
                        state_q <= ST_RELEASE;
                    end else if (rep_cnt_q == {CNT_W{1'b0}}) begin
                        pulse_q   <= pulse_sel(owner_q, dir_q);
                        rep_cnt_q <= PERIOD_LOAD;
                        state_q   <= ST_REPEAT;
                    end else begin
                        rep_cnt_q <= rep_cnt_q - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!any_btn_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                default: begin
                    state_q <= ST_RELEASE;
                end
            endcase
        end
    end

    assign set_mode_o    = deb_s[0];
    assign hour_inc_o    = pulse_q[0];
    assign hour_dec_o    = pulse_q[1];
    assign minute_inc_o  = pulse_q[2];
    assign minute_dec_o  = pulse_q[3];
    assign seconds_inc_o = pulse_q[4];
    assign seconds_dec_o = pulse_q[5];

endmodule

// File: tb/tb_tt_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_time_set_ctrl
// Self-checking bench for tt_time_set_ctrl. A behavioural model predicts
// set_mode_o and the six pulse outputs every cycle. Debounce is modelled as
// "the raw level seen two edges ago has been opposite for D samples".
// Repeat timing is modelled with absolute due-times. Directed scenarios add
// hand-computed pulse edges on top.
// ---------------------------------------------------------------------------
module tb_tt_time_set_ctrl;

    localparam int D  = 16;
    localparam int RD = 32;
    localparam int RP = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic time_set = 1'b0, id_sw = 1'b0, hour_btn = 1'b0, minute_btn = 1'b0, seconds_btn = 1'b0;
    logic set_mode_o, hour_inc_o, hour_dec_o, minute_inc_o, minute_dec_o, seconds_inc_o, seconds_dec_o;
    logic [5:0] dut_vec;

    int n_checks = 0;
    int n_err    = 0;
    int edge_no  = 0;
    bit chk_en   = 1'b0;

    // Pulse log of the DUT: edge number and pulse vector.
    int         pl_edge[$];
    logic [5:0] pl_vec[$];

    // Model state
    bit [4:0] h [D+1];
    bit [4:0] deb_m = 5'd0;
    bit [4:0] raw_m;
    bit [2:0] b_m;
    bit       set_m;
    bit       all_diff;
    int       m_mode  = 0;   // 0 idle, 1 active, 2 blocked
    int       m_owner = 0;
    bit       m_dir   = 1'b0;
    int       m_next  = 0;
    bit [5:0] exp_pulse = 6'd0;
    bit       exp_set   = 1'b0;

    tt_time_set_ctrl #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .time_set_i(time_set), .id_switch_i(id_sw),
        .hour_btn_i(hour_btn), .minute_btn_i(minute_btn), .seconds_btn_i(seconds_btn),
        .set_mode_o(set_mode_o),
        .hour_inc_o(hour_inc_o), .hour_dec_o(hour_dec_o),
        .minute_inc_o(minute_inc_o), .minute_dec_o(minute_dec_o),
        .seconds_inc_o(seconds_inc_o), .seconds_dec_o(seconds_dec_o)
    );

    assign dut_vec = {seconds_dec_o, seconds_inc_o, minute_dec_o, minute_inc_o, hour_dec_o, hour_inc_o};

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_no);
        end
    endtask

    // Model: FSM decisions use the debounced levels from before this edge.
    always @(posedge clk) begin
        edge_no = edge_no + 1;
        raw_m = {seconds_btn, minute_btn, hour_btn, id_sw, time_set};
        if (rst_i) begin
            for (int k = 0; k <= D; k++) h[k] = 5'd0;
            deb_m = 5'd0;
            m_mode = 0;
            exp_pulse = 6'd0;
        end else begin
            set_m = deb_m[0];
            b_m = deb_m[4:2];
            exp_pulse = 6'd0;
            if (m_mode == 0) begin
                if (set_m && b_m != 3'd0) begin
                    m_owner = b_m[0] ? 0 : (b_m[1] ? 1 : 2);
                    m_dir = deb_m[1];
                    exp_pulse[m_owner*2 + (m_dir ? 0 : 1)] = 1'b1;
                    m_next = edge_no + RD;
                    m_mode = 1;
                end else if (b_m != 3'd0) begin
                    m_mode = 2;
                end
            end else if (m_mode == 1) begin
                if (!set_m || !b_m[m_owner]) begin
                    m_mode = 2;
                end else if (edge_no == m_next) begin
                    exp_pulse[m_owner*2 + (m_dir ? 0 : 1)] = 1'b1;
                    m_next = edge_no + RP;
                end
            end else if (b_m == 3'd0) begin
                m_mode = 0;
            end
            // h[k] holds the raw sample from k+1 edges ago; the window is h[1..D].
            for (int i = 0; i < 5; i++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++) if (h[k][i] == deb_m[i]) all_diff = 1'b0;
                if (all_diff) deb_m[i] = ~deb_m[i];
            end
            for (int k = D; k >= 1; k--) h[k] = h[k-1];
            h[0] = raw_m;
        end
        exp_set = deb_m[0];
    end

    // Every-cycle comparison against the model, plus pulse logging.
    always @(negedge clk) begin
        if (chk_en) begin
            check("set_mode", int'(set_mode_o), int'(exp_set));
            check("pulses", int'(dut_vec), int'(exp_pulse));
            check("onehot", int'($countones(dut_vec) <= 1), 1);
            if (dut_vec != 6'd0) begin
                pl_edge.push_back(edge_no);
                pl_vec.push_back(dut_vec);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        pl_edge.delete();
        pl_vec.delete();
    endtask

    task automatic check_all_vec(input string name, input logic [5:0] exp);
        foreach (pl_vec[i]) check(name, int'(pl_vec[i]), int'(exp));
    endtask

    int n0;
    int r_last;

    initial begin
        idle(1);
        chk_en = 1'b1;
        idle(2);
        rst_i = 1'b0;

        // Idle after reset
        check("rst_set_mode", int'(set_mode_o), 0);
        check("rst_pulses", int'(dut_vec), 0);
        idle(200);
        check("idle_pulse_count", pl_edge.size(), 0);
        check("idle_set_mode", int'(set_mode_o), 0);

        // S1: hour held 30 cycles, single increment, no repeat
        time_set = 1'b1; id_sw = 1'b1;
        idle(40);
        check("s1_set_mode", int'(set_mode_o), 1);
        clear_log();
        @(negedge clk); hour_btn = 1'b1; n0 = edge_no + 1;
        idle(30); hour_btn = 1'b0;
        idle(60);
        check("s1_count", pl_edge.size(), 1);
        if (pl_edge.size() >= 1) begin
            check("s1_edge", pl_edge[0] - n0, 18);
            check("s1_vec", int'(pl_vec[0]), 1);
        end

        // S2: minute held 100 cycles with decrement, auto-repeat
        id_sw = 1'b0;
        idle(40);
        clear_log();
        @(negedge clk); minute_btn = 1'b1; n0 = edge_no + 1;
        idle(100); minute_btn = 1'b0;
        idle(60);
        check("s2_count", pl_edge.size(), 10);
        if (pl_edge.size() >= 3) begin
            check("s2_first", pl_edge[0] - n0, 18);
            check("s2_second", pl_edge[1] - n0, 50);
            check("s2_third", pl_edge[2] - n0, 58);
            check("s2_last", pl_edge[pl_edge.size()-1] - n0, 114);
        end
        check_all_vec("s2_vec", 6'b001000);

        // S3: hour+seconds together, only hour; seconds needs a fresh press
        id_sw = 1'b1;
        idle(40);
        clear_log();
        @(negedge clk); hour_btn = 1'b1; seconds_btn = 1'b1; n0 = edge_no + 1;
        idle(25); hour_btn = 1'b0;
        idle(50); seconds_btn = 1'b0;
        idle(40);
        check("s3_count", pl_edge.size(), 1);
        if (pl_edge.size() >= 1) begin
            check("s3_edge", pl_edge[0] - n0, 18);
            check("s3_vec", int'(pl_vec[0]), 1);
        end
        clear_log();
        @(negedge clk); seconds_btn = 1'b1; n0 = edge_no + 1;
        idle(25); seconds_btn = 1'b0;
        idle(40);
        check("s3b_count", pl_edge.size(), 1);
        if (pl_edge.size() >= 1) begin
            check("s3b_edge", pl_edge[0] - n0, 18);
            check("s3b_vec", int'(pl_vec[0]), 16);
        end

        // S4: glitch, press without set mode, set mode raised while held
        clear_log();
        @(negedge clk); hour_btn = 1'b1;
        idle(10); hour_btn = 1'b0;
        idle(40);
        check("s4_glitch_count", pl_edge.size(), 0);
        time_set = 1'b0;
        idle(40);
        check("s4_set_mode_off", int'(set_mode_o), 0);
        hour_btn = 1'b1;
        idle(60);
        time_set = 1'b1;
        idle(60);
        check("s4_set_mode_on", int'(set_mode_o), 1);
        hour_btn = 1'b0;
        idle(40);
        check("s4_held_count", pl_edge.size(), 0);
        @(negedge clk); hour_btn = 1'b1; n0 = edge_no + 1;
        idle(25); hour_btn = 1'b0;
        idle(40);
        check("s4_repress_count", pl_edge.size(), 1);
        if (pl_edge.size() >= 1) check("s4_repress_edge", pl_edge[0] - n0, 18);

        // S5: reset during repeat, then recover with button still held
        clear_log();
        @(negedge clk); minute_btn = 1'b1; n0 = edge_no + 1;
        idle(60);
        check("s5_pre_count", pl_edge.size(), 3);
        rst_i = 1'b1;
        idle(1);
        check("s5_rst_pulses", int'(dut_vec), 0);
        check("s5_rst_set_mode", int'(set_mode_o), 0);
        idle(2);
        rst_i = 1'b0; r_last = edge_no;
        clear_log();
        idle(30); id_sw = 1'b0;
        idle(45); minute_btn = 1'b0;
        idle(60);
        check("s5_count", pl_edge.size(), 7);
        if (pl_edge.size() >= 2) begin
            check("s5_first", pl_edge[0] - r_last, 19);
            check("s5_second", pl_edge[1] - r_last, 51);
        end
        check_all_vec("s5_vec", 6'b000100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
